display_scan: RTL
=================

Name: display_scan

Overview:
- Multiplexed digit scanner for the common-anode seven-segment display.
- Takes DIGITS packed BCD digits from the clock/counter logic and time-multiplexes them onto one shared 4-bit value bus, which feeds the BCD-to-segment decoder.
- Drives active-low per-digit anode enables.
- Inserts dead time between digits against ghosting; supports leading-zero blanking and glitch-free frame-synchronous digit capture.

Parameters:
- DIGITS, 4: number of digits scanned, 1..8.
- PRESCALE, 50000: clk cycles per digit slot (drive plus dead time); must exceed DEAD.
- DEAD, 64: clk cycles of all-off blanking at the end of each slot; must be at least 1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset.
- enable  in  1  scan enable; 0 blanks the display.
- lzb  in  1  leading-zero blanking enable.
- digits  in  4*DIGITS  packed BCD; digit i = digits[4i+3:4i]; digit 0 is rightmost.
- value  out  4  BCD to the segment decoder; 4'hF while blanked (decoder shows all-off).
- anode_n  out  DIGITS  active-low digit enables; at most one bit low at any time.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Registers:
  - state: DRIVE or BLANK.
  - idx: clog2(DIGITS) bits, minimum 1.
  - cnt: slot counter, clog2(PRESCALE) bits.
  - shadow: 4*DIGITS bits.
- All outputs are registered and consistent with state/idx in the same cycle.
- Reset (rst=1 at an edge):
  - state=BLANK, idx=DIGITS-1, cnt=0, shadow=0.
  - value=4'hF, anode_n=all 1s, frame_tick=0.
- BLANK:
  - anode_n all 1s, value=4'hF.
  - cnt counts 0..DEAD-1.
  - At cnt==DEAD-1: state becomes DRIVE, idx becomes (idx==DIGITS-1 ? 0 : idx+1), cnt=0.
- Entering DRIVE with idx=0:
  - shadow loads digits on that same edge.
  - frame_tick=1 for exactly that first DRIVE cycle.
  - Digits changing mid-frame therefore never tear a frame.
- DRIVE:
  - value=shadow digit idx; anode_n bit idx=0, others 1.
  - cnt counts 0..PRESCALE-DEAD-1, then state becomes BLANK, cnt=0.
- Slot length: exactly PRESCALE cycles. Frame length: exactly DIGITS*PRESCALE cycles.
- First DRIVE (digit 0) begins DEAD cycles after the first edge with rst=0.
- Leading-zero blanking (lzb=1):
  - A digit i>0 is suppressed when shadow digits i..DIGITS-1 are all 0.
  - A suppressed digit's DRIVE slot keeps timing but outputs anode_n all 1s and value=4'hF.
  - Digit 0 is never suppressed.
  - lzb is sampled every cycle.
- Non-BCD digit (A-F): passed through unchanged; it is not treated as zero for blanking.
- enable=0 (sampled each edge):
  - Forces the reset values of state/idx/cnt/outputs; shadow is held.
  - On the first edge with enable=1, behaviour is identical to leaving reset.
- rst has priority over enable. Reset mid-slot aborts immediately; no partial-slot completion.
- DIGITS=1: idx stays 0; every slot is a frame start (frame_tick every PRESCALE cycles).

Optional Feature:
DISPLAY_SCAN_DP_EN
- Defined:
  - Adds input dp [DIGITS-1:0] and output dp_n (1 bit, registered, active-low).
  - dp is captured into a shadow at frame start, alongside digits.
  - dp_n=0 only in a DRIVE cycle of a non-suppressed digit idx with shadow dp[idx]=1; otherwise 1.
  - dp_n resets to 1.
  - A set dp bit on a digit counts as non-zero for leading-zero blanking (digit not suppressed).
- Undefined: no dp/dp_n ports; behaviour otherwise identical.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=8, DEAD=2.
- Reset sequence: rst high 3 cycles, digits=16'h1234, enable=1, lzb=0.
  - Required response: blank for 2 cycles.
  - Then value=4, anode_n=1110 for 6 cycles; frame_tick=1 on the first of these.
  - Then 2 blank cycles, then value=3, anode_n=1101; pattern continues through 2, 1.
  - frame_tick repeats every 32 cycles.
- Tear-free capture: change digits from 16'h1234 to 16'h5678 during digit 2's slot.
  - Required response: digits 2 and 3 still show 2 and 1.
  - Next frame shows 8, 7, 6, 5.
- Leading-zero blanking: lzb=1, digits=16'h0040.
  - Required response: digit 0 shows 0; digit 1 shows 4.
  - Digits 2 and 3 slots show anode_n=1111 and value=F.
  - All-zero digits shows only digit 0 (value 0).
- Enable gating: drop enable mid-DRIVE of digit 1.
  - Required response: next cycle anode_n=1111, value=F, frame_tick=0 for as long as enable=0.
  - Re-enable: 2 blank cycles, then digit 0 with frame_tick.
- Reset mid-operation: assert rst for 1 cycle during DRIVE of digit 3.
  - Required response: outputs go to the reset values on that edge.
  - Restart timing matches the reset sequence scenario exactly.
- With DISPLAY_SCAN_DP_EN defined: dp=4'b0100, lzb=1, digits=16'h0000.
  - Required response: digit 2 is driven (value 0, anode_n=1011, dp_n=0).
  - Digit 3 is suppressed; dp_n=1 in all other cycles.

Source files
------------

// File: rtl/display_scan.sv
// Multiplexed common-anode seven-segment scanner with dead time, leading-zero blanking and frame-synchronous capture.
// Optional decimal-point support is enabled by defining DISPLAY_SCAN_DP_EN.
module display_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  lzb,
    input  logic [4*DIGITS-1:0]   digits,
`ifdef DISPLAY_SCAN_DP_EN
    input  logic [DIGITS-1:0]     dp,
    output logic                  dp_n,
`endif
    output logic [3:0]            value,
    output logic [DIGITS-1:0]     anode_n,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(DEAD - 1);
    localparam logic [CNT_W-1:0] CNT_DRIVE_END = CNT_W'(PRESCALE - DEAD - 1);

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [3:0]          value_q, value_d;
    logic [DIGITS-1:0]   anode_n_q, anode_n_d;
    logic                frame_tick_q, frame_tick_d;
    logic                frame_start;
    logic [DIGITS-1:0]   dp_shadow_d;
    logic [DIGITS-1:0]   suppress;
    logic                above_nz;
    logic                show;

`ifdef DISPLAY_SCAN_DP_EN
    logic [DIGITS-1:0]   dp_shadow_q;
    logic                dp_n_q, dp_n_d;
`endif

    // Slot sequencing: BLANK tail of one slot hands over to DRIVE of the next digit.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + 1'b1;
        shadow_d    = shadow_q;
        frame_start = 1'b0;
`ifdef DISPLAY_SCAN_DP_EN
        dp_shadow_d = dp_shadow_q;
`else
        dp_shadow_d = '0;
`endif
        if (state_q == ST_BLANK) begin
            if (cnt_q == CNT_BLANK_END) begin
                state_d = ST_DRIVE;
                cnt_d   = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                if (idx_d == '0) begin
                    frame_start = 1'b1;
                    shadow_d    = digits;
`ifdef DISPLAY_SCAN_DP_EN
                    dp_shadow_d = dp;
`endif
                end
            end
        end else if (cnt_q == CNT_DRIVE_END) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
        end

        // Disabled looks exactly like reset, but the captured frame survives.
        if (!enable) begin
            state_d     = ST_BLANK;
            idx_d       = IDX_LAST;
            cnt_d       = '0;
            frame_start = 1'b0;
            shadow_d    = shadow_q;
`ifdef DISPLAY_SCAN_DP_EN
            dp_shadow_d = dp_shadow_q;
`endif
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero with no dp set.
    always_comb begin
        above_nz = 1'b0;
        suppress = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above_nz    = above_nz | (shadow_d[4*i +: 4] != 4'h0) | dp_shadow_d[i];
            suppress[i] = (i != 0) && !above_nz;
        end
    end

    // Outputs are derived from next-state values so they register in step with state/idx.
    always_comb begin
        show         = (state_d == ST_DRIVE) && !(lzb && suppress[idx_d]);
        value_d      = show ? shadow_d[4*idx_d +: 4] : 4'hF;
        anode_n_d    = '1;
        if (show) begin
            anode_n_d[idx_d] = 1'b0;
        end
        frame_tick_d = frame_start;
`ifdef DISPLAY_SCAN_DP_EN
        dp_n_d       = !(show && dp_shadow_d[idx_d]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            idx_q        <= IDX_LAST;
            cnt_q        <= '0;
            shadow_q     <= '0;
            value_q      <= 4'hF;
            anode_n_q    <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            value_q      <= value_d;
            anode_n_q    <= anode_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef DISPLAY_SCAN_DP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_shadow_q <= '0;
            dp_n_q      <= 1'b1;
        end else begin
            dp_shadow_q <= dp_shadow_d;
            dp_n_q      <= dp_n_d;
        end
    end

    assign dp_n = dp_n_q;
`endif

    assign value      = value_q;
    assign anode_n    = anode_n_q;
    assign frame_tick = frame_tick_q;

endmodule
